// File: rtl/alu_pkg.sv
// Shared command/response types and the single-op execute function for the multichannel ALU.
// alu_exec works at ExecWidth bits; callers zero-extend operands and keep the low DATA_WIDTH bits.
package alu_pkg;

  typedef enum logic [2:0] {
    CmdNop = 3'd0,
    CmdAdd = 3'd1,
    CmdSub = 3'd2,
    CmdAnd = 3'd3,
    CmdOr  = 3'd4,
    CmdXor = 3'd5,
    CmdShl = 3'd6,
    CmdShr = 3'd7
  } command_names_t;

  typedef enum logic [1:0] {
    RespNone     = 2'd0,
    RespSuccess  = 2'd1,
    RespOverflow = 2'd2,
    RespInvalid  = 2'd3
  } response_names_t;

  // Widest DATA_WIDTH the execute function supports.
  localparam int unsigned ExecWidth = 64;

  typedef struct packed {
    logic [ExecWidth-1:0] data;
    response_names_t      resp;
  } exec_result_t;

  function automatic exec_result_t alu_exec(input command_names_t       cmd,
                                            input logic [ExecWidth-1:0] a,
                                            input logic [ExecWidth-1:0] b,
                                            input int unsigned          width);
    logic [ExecWidth:0]   full;
    logic [ExecWidth-1:0] mask;
    exec_result_t         res;
    mask     = ExecWidth'(({{ExecWidth{1'b0}}, 1'b1} << width) - (ExecWidth + 1)'(1));
    full     = '0;
    res.data = '0;
    res.resp = RespSuccess;
    case (cmd)
      CmdAdd: begin
        full     = {1'b0, a} + {1'b0, b};
        res.data = full[ExecWidth-1:0] & mask;
        // Operands are below 2**width, so anything above bit width-1 is the carry.
        if ((full >> width) != '0) res.resp = RespOverflow;
      end
      CmdSub: begin
        full     = {1'b0, a} - {1'b0, b};
        res.data = full[ExecWidth-1:0] & mask;
        if (b > a) res.resp = RespOverflow;
      end
      CmdAnd: res.data = a & b;
      CmdOr:  res.data = a | b;
      CmdXor: res.data = a ^ b;
      CmdShl: begin
        if (b >= ExecWidth'(width)) res.resp = RespInvalid;
        else                        res.data = (a << b) & mask;
      end
      CmdShr: begin
        if (b >= ExecWidth'(width)) res.resp = RespInvalid;
        else                        res.data = a >> b;
      end
      default: res.resp = RespNone;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Per-channel synchronous command FIFO with occupancy output.
// A push while full or a pop while empty is ignored.
module alu_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [LevelW-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LevelW'(Depth));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push != do_pop) level_q <= do_push ? level_q + 1'b1 : level_q - 1'b1;
    end
  end

  // Storage needs no reset: the level counter gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_multichannel.sv
// Multi-channel ALU: per-channel command FIFOs, round-robin issue into a shared
// fixed-latency pipeline, and one valid/ready result slot per channel.
module alu_multichannel
  import alu_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PIPE_STAGES  = 3,
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                    clock_i,
  input  logic                                    reset_ni,
  input  logic            [NUM_CHANNELS-1:0]                 in_valid_i,
  output logic            [NUM_CHANNELS-1:0]                 in_ready_o,
  input  command_names_t  [NUM_CHANNELS-1:0]                 in_command_i,
  input  logic            [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data1_i,
  input  logic            [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data2_i,
  output logic            [NUM_CHANNELS-1:0]                 out_valid_o,
  input  logic            [NUM_CHANNELS-1:0]                 out_ready_i,
  output logic            [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_data_o,
  output response_names_t [NUM_CHANNELS-1:0]                 out_response_o,
  output logic            [NUM_CHANNELS-1:0][LevelW-1:0]     fifo_level_o
);

  localparam int unsigned TagW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef struct packed {
    command_names_t        cmd;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } cmd_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [TagW-1:0]       tag;
    logic [DATA_WIDTH-1:0] data;
    response_names_t       resp;
  } pipe_stage_t;

  cmd_entry_t  [NUM_CHANNELS-1:0] fifo_wdata, head;
  logic        [NUM_CHANNELS-1:0] fifo_push, fifo_empty, fifo_full, eligible, grant;
  logic        [TagW-1:0]         rr_ptr_q, rr_ptr_d, grant_idx;
  logic                           grant_any;
  cmd_entry_t                     issue_entry;
  exec_result_t                   issue_res;
  pipe_stage_t [PIPE_STAGES-1:0]  pipe_q, pipe_d;
  pipe_stage_t                    pipe_last;

  logic [NUM_CHANNELS-1:0]                 busy_q, busy_d;
  logic [NUM_CHANNELS-1:0]                 out_valid_q, out_valid_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_CHANNELS-1:0][1:0]            out_resp_q, out_resp_d;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    // NOPs are dropped at the door and never occupy a FIFO entry.
    assign fifo_push[c]  = in_valid_i[c] & ~fifo_full[c] & (in_command_i[c] != CmdNop);
    assign fifo_wdata[c] = '{cmd: in_command_i[c], a: in_data1_i[c], b: in_data2_i[c]};
    assign eligible[c]   = ~fifo_empty[c] & ~busy_q[c];
    assign in_ready_o[c] = ~fifo_full[c];
    assign out_response_o[c] = response_names_t'(out_resp_q[c]);

    alu_cmd_fifo #(
      .Width($bits(cmd_entry_t)),
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clock_i),
      .rst_ni (reset_ni),
      .push_i (fifo_push[c]),
      .wdata_i(fifo_wdata[c]),
      .pop_i  (grant[c]),
      .rdata_o(head[c]),
      .empty_o(fifo_empty[c]),
      .full_o (fifo_full[c]),
      .level_o(fifo_level_o[c])
    );
  end

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + i) % NUM_CHANNELS;
      if (!grant_any && eligible[TagW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = TagW'(idx);
      end
    end
  end

  assign grant    = grant_any ? (NUM_CHANNELS'(1) << grant_idx) : '0;
  assign rr_ptr_d = !grant_any ? rr_ptr_q :
                    ((32'(grant_idx) + 1 >= NUM_CHANNELS) ? '0 : grant_idx + 1'b1);

  assign issue_entry = head[grant_idx];
  assign issue_res   = alu_exec(issue_entry.cmd, ExecWidth'(issue_entry.a),
                                ExecWidth'(issue_entry.b), DATA_WIDTH);

  if (DATA_WIDTH < ExecWidth) begin : g_exec_hi
    logic unused_exec_hi;
    assign unused_exec_hi = ^issue_res.data[ExecWidth-1:DATA_WIDTH];
  end

  // The result is computed at issue; the remaining stages only carry it to its slot.
  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = grant_any;
    pipe_d[0].tag   = grant_idx;
    pipe_d[0].data  = issue_res.data[DATA_WIDTH-1:0];
    pipe_d[0].resp  = issue_res.resp;
    for (int unsigned s = 1; s < PIPE_STAGES; s++) pipe_d[s] = pipe_q[s-1];
  end

  assign pipe_last = pipe_q[PIPE_STAGES-1];

  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_resp_d  = out_resp_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (out_valid_q[c] && out_ready_i[c]) begin
        out_valid_d[c] = 1'b0;
        out_data_d[c]  = '0;
        out_resp_d[c]  = RespNone;
        busy_d[c]      = 1'b0;
      end
      // One op in flight per channel, so the slot is always free when its result lands.
      if (pipe_last.valid && (pipe_last.tag == TagW'(c))) begin
        out_valid_d[c] = 1'b1;
        out_data_d[c]  = pipe_last.data;
        out_resp_d[c]  = pipe_last.resp;
      end
      if (grant[c]) busy_d[c] = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_q    <= '0;
      pipe_q      <= '0;
      busy_q      <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_resp_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pipe_q      <= pipe_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_resp_q  <= out_resp_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_alu_multichannel.sv
// Self-checking bench for alu_multichannel: directed latency/arbitration/backpressure/reset
// scenarios plus randomized traffic scored against a per-channel result queue model.
module tb_alu_multichannel;
  import alu_pkg::*;

  localparam int NCh = 4;

  logic                              clk;
  logic                              rst_n;
  logic            [NCh-1:0]         in_valid;
  logic            [NCh-1:0]         in_ready;
  command_names_t  [NCh-1:0]         in_command;
  logic            [NCh-1:0][31:0]   in_data1;
  logic            [NCh-1:0][31:0]   in_data2;
  logic            [NCh-1:0]         out_valid;
  logic            [NCh-1:0]         out_ready;
  logic            [NCh-1:0][31:0]   out_data;
  response_names_t [NCh-1:0]         out_response;
  logic            [NCh-1:0][2:0]    fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q [NCh][$];
  int rx_cnt [NCh];

  alu_multichannel #(
    .NUM_CHANNELS(4),
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (4),
    .PIPE_STAGES (3)
  ) dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_command_i  (in_command),
    .in_data1_i    (in_data1),
    .in_data2_i    (in_data2),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_response_o(out_response),
    .fifo_level_o  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {resp[1:0], data[31:0]} from the arithmetic rules.
  function automatic logic [33:0] ref_exec(input int cmd, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] s;
    case (cmd)
      1: begin
        s = 64'(a) + 64'(b);
        return {(s > 64'hFFFF_FFFF) ? 2'd2 : 2'd1, s[31:0]};
      end
      2: return {(b > a) ? 2'd2 : 2'd1, a - b};
      3: return {2'd1, a & b};
      4: return {2'd1, a | b};
      5: return {2'd1, a ^ b};
      6: return (b >= 32) ? {2'd3, 32'd0} : {2'd1, a << b};
      7: return (b >= 32) ? {2'd3, 32'd0} : {2'd1, a >> b};
      default: return 34'd0;
    endcase
  endfunction

  // Score this cycle's handshakes, then advance to 1ns after the next rising edge.
  task automatic tick();
    logic [33:0] e;
    if (rst_n) begin
      for (int c = 0; c < NCh; c++) begin
        if (out_valid[c]) begin
          if (out_ready[c]) begin
            if (exp_q[c].size() == 0) begin
              check_eq($sformatf("ch%0d_spurious_valid", c), 64'(out_valid[c]), 64'd0);
            end else begin
              e = exp_q[c].pop_front();
              check_eq($sformatf("ch%0d_data", c), 64'(out_data[c]), 64'(e[31:0]));
              check_eq($sformatf("ch%0d_resp", c), 64'(out_response[c]), 64'(e[33:32]));
              rx_cnt[c]++;
            end
          end
        end else begin
          check_eq($sformatf("ch%0d_idle_data", c), 64'(out_data[c]), 64'd0);
          check_eq($sformatf("ch%0d_idle_resp", c), 64'(out_response[c]), 64'd0);
        end
      end
      for (int c = 0; c < NCh; c++) begin
        if (in_valid[c] && in_ready[c] && in_command[c] != CmdNop)
          exp_q[c].push_back(ref_exec(int'(in_command[c]), in_data1[c], in_data2[c]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input command_names_t cmd, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid[ch]   = 1'b1;
    in_command[ch] = cmd;
    in_data1[ch]   = a;
    in_data2[ch]   = b;
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCh; c++) begin
      exp_q[c].delete();
      rx_cnt[c] = 0;
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic wait_result(input int ch, input logic [31:0] d, input logic [1:0] r);
    int n = 0;
    while (!out_valid[ch] && n < 20) begin
      tick();
      n++;
    end
    check_eq($sformatf("wait_ch%0d_valid", ch), 64'(out_valid[ch]), 64'd1);
    check_eq($sformatf("wait_ch%0d_data", ch), 64'(out_data[ch]), 64'(d));
    check_eq($sformatf("wait_ch%0d_resp", ch), 64'(out_response[ch]), 64'(r));
  endtask

  initial begin
    int acc;
    int n;
    logic [3:0]  exp_v;
    logic [11:0] exp_lvl;
    rst_n      = 1'b0;
    in_valid   = '0;
    in_command = {NCh{CmdNop}};
    in_data1   = '0;
    in_data2   = '0;
    out_ready  = '1;
    clear_model();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_resp", 64'(out_response), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'hF);
    check_eq("rst_fifo_level", 64'(fifo_level), 64'd0);
    check_eq("rst_out_data_lo", out_data[1:0], 64'd0);
    check_eq("rst_out_data_hi", out_data[3:2], 64'd0);
    rst_n = 1'b1;
    tick();

    // ADD with carry-out, exact latency.
    drive(0, CmdAdd, 32'hFFFF_FFFF, 32'h1);
    tick();
    in_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("lat_add_k%0d", k), 64'(out_valid[0]), 64'(k == 4));
    end
    check_eq("add_ovf_data", 64'(out_data[0]), 64'd0);
    check_eq("add_ovf_resp", 64'(out_response[0]), 64'(RespOverflow));
    tick();
    drive(0, CmdSub, 32'd5, 32'd3);
    tick();
    in_valid = '0;
    wait_result(0, 32'd2, 2'(RespSuccess));
    tick();

    // All channels at once from a fresh pointer: one issue per cycle in channel order.
    apply_reset();
    tick();
    for (int c = 0; c < NCh; c++) drive(c, CmdAdd, 32'd1, 32'd1);
    tick();
    in_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k >= 4 && k <= 7) ? 4'(4'b0001 << (k - 4)) : 4'b0000;
      check_eq($sformatf("rr_valid_k%0d", k), 64'(out_valid), 64'(exp_v));
    end

    // Backpressure on ch1: five accepted, FIFO full.
    out_ready[1] = 1'b0;
    rx_cnt[1]    = 0;
    acc          = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, CmdAdd, 32'd100 + 32'(i), 32'(i));
      if (in_ready[1]) acc++;
      tick();
    end
    in_valid = '0;
    check_eq("bp_accepted", 64'(acc), 64'd5);
    check_eq("bp_level", 64'(fifo_level[1]), 64'd4);
    check_eq("bp_in_ready", 64'(in_ready[1]), 64'd0);
    check_eq("bp_held_valid", 64'(out_valid[1]), 64'd1);
    out_ready[1] = 1'b1;
    n = 0;
    while (rx_cnt[1] < 5 && n < 60) begin
      tick();
      n++;
    end
    check_eq("bp_drained", 64'(rx_cnt[1]), 64'd5);

    // Shift range and NOP handling.
    drive(2, CmdShl, 32'd1, 32'd32);
    tick();
    in_valid = '0;
    wait_result(2, 32'd0, 2'(RespInvalid));
    tick();
    drive(2, CmdShr, 32'd8, 32'd3);
    tick();
    in_valid = '0;
    wait_result(2, 32'd1, 2'(RespSuccess));
    tick();
    drive(3, CmdNop, 32'd5, 32'd5);
    check_eq("nop_in_ready", 64'(in_ready[3]), 64'd1);
    tick();
    in_valid = '0;
    check_eq("nop_level", 64'(fifo_level[3]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("nop_no_valid_%0d", k), 64'(out_valid[3]), 64'd0);
    end

    // Asynchronous reset with work queued and in flight.
    out_ready = '0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCh; c++) drive(c, CmdAdd, $urandom, $urandom);
      tick();
    end
    in_valid = '0;
    repeat (8) tick();
    exp_lvl = {4{3'd1}};
    check_eq("pre_rst_valid", 64'(out_valid), 64'hF);
    check_eq("pre_rst_level", 64'(fifo_level), 64'(exp_lvl));
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_level", 64'(fifo_level), 64'd0);
    check_eq("async_rst_ready", 64'(in_ready), 64'hF);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = '1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("post_rst_quiet_%0d", k), 64'(out_valid), 64'd0);
    end

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCh; c++) begin
        in_valid[c]   = ($urandom_range(0, 1) == 1);
        in_command[c] = command_names_t'($urandom_range(0, 7));
        in_data1[c]   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
        in_data2[c]   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
        out_ready[c]  = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    in_valid  = '0;
    out_ready = '1;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && n < 300) begin
      tick();
      n++;
    end
    for (int c = 0; c < NCh; c++)
      check_eq($sformatf("drain_ch%0d", c), 64'(exp_q[c].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
